// File: rtl/bz_serializer_if.sv
// bz_serializer_if: core-word handshake plus outbound router FIFO write port.
// Ports: master drives in_* and isfull; slave (the serializer) drives in_a/out_data/wrreq.
interface bz_serializer_if #(
    parameter int NPCcode  = 8,
    parameter int NPCdata  = 24,
    parameter int NPCroute = 10
);
    logic [NPCcode+NPCdata-1:0] in_data;
    logic [NPCroute-1:0]        in_route;
    logic                       in_more;
    logic                       in_v;
    logic                       in_a;
    logic [NPCroute:0]          out_data;
    logic                       wrreq;
    logic                       isfull;

    modport master (
        output in_data, in_route, in_more, in_v, isfull,
        input  in_a, out_data, wrreq
    );

    modport slave (
        input  in_data, in_route, in_more, in_v, isfull,
        output in_a, out_data, wrreq
    );
endinterface

// File: rtl/bz_serializer.sv
// bz_serializer: splits 32-bit core words into 11-bit {payload, tail} router flits
// (one header per worm, three data flits per word) and writes them to the router FIFO.
// Ports: clk, reset (async, active-high), bus (bz_serializer_if.slave), and err_msb
// (sticky, only when BZ_SER_MSB_CHECK_EN is defined).
module bz_serializer #(
    parameter int NPCcode  = 8,
    parameter int NPCdata  = 24,
    parameter int NPCroute = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    bz_serializer_if.slave       bus
`ifdef BZ_SER_MSB_CHECK_EN
    ,
    output logic                 err_msb
`endif
);

    localparam int WW = NPCcode + NPCdata;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        D0,
        D1,
        D2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [WW-3:0]       word_q;
    logic [NPCroute-1:0] route_q;
    logic                more_q;
    logic                worm_open;
    logic                rst_hold;
    logic                xfer;
    logic                adv;

    assign xfer = bus.in_v && bus.in_a;
    assign adv  = bus.wrreq;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a stalled flit (isfull) keeps the state
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (xfer) state_nxt = worm_open ? D0 : HDR;
            HDR:  if (adv)  state_nxt = D0;
            D0:   if (adv)  state_nxt = D1;
            D1:   if (adv)  state_nxt = D2;
            D2:   if (adv)  state_nxt = IDLE;
            default:        state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.in_a     = (state == IDLE) && !reset && !rst_hold;
        bus.wrreq    = (state != IDLE) && !bus.isfull;
        bus.out_data = '0;
        unique case (state)
            IDLE:    bus.out_data = '0;
            HDR:     bus.out_data = {route_q, 1'b0};
            D0:      bus.out_data = {word_q[29:20], 1'b0};
            D1:      bus.out_data = {word_q[19:10], 1'b0};
            D2:      bus.out_data = {word_q[9:0], !more_q};
            default: bus.out_data = '0;
        endcase
    end

    // Holds in_a low for the partial cycle between reset release and the first edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_hold <= 1'b1;
        end else begin
            rst_hold <= 1'b0;
        end
    end

    // Held word; route only refreshed when a header will be sent
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q    <= '0;
            route_q   <= '0;
            more_q    <= 1'b0;
            worm_open <= 1'b0;
        end else begin
            if (xfer) begin
                word_q <= bus.in_data[WW-3:0];
                more_q <= bus.in_more;
                if (!worm_open) begin
                    route_q <= bus.in_route;
                end
            end
            if (state == D2 && adv) begin
                worm_open <= more_q;
            end
        end
    end

`ifdef BZ_SER_MSB_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_msb <= 1'b0;
        end else if (xfer && (bus.in_data[WW-1:WW-2] != 2'b00)) begin
            err_msb <= 1'b1;
        end
    end
`else
    // The two top code bits are never routed
    logic unused_msb;
    assign unused_msb = ^bus.in_data[WW-1:WW-2];
`endif

endmodule
